// File: rtl/pixel_clip_fifo.sv
// rtl/pixel_clip_fifo.sv - clips engine pixels to the visible screen and buffers survivors for the VGA adapter
//
// Purpose:
//   Sits between the circle drawing engine and the VGA adapter. Pixels that
//   fall outside the SCREEN_W x SCREEN_H window are counted and discarded.
//   In-range pixels are queued in a DEPTH-entry first-word-fall-through FIFO
//   and offered to the adapter with a plot/ready handshake. The engine cannot
//   be stalled, so a pixel that arrives while the FIFO is full (and nothing
//   leaves in the same cycle) is dropped and the sticky overflow flag is set.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 synchronous clear of FIFO, clip_count and overflow
//   in_x/in_y/in_colour   pixel from the engine, qualified by in_plot
//   out_x/out_y/out_colour head pixel, qualified by out_plot
//   out_ready             adapter takes the head when out_plot is high
//   fifo_full/fifo_empty  occupancy flags
//   clip_count            saturating count of clipped pixels
//   overflow              sticky flag for pixels lost to a full FIFO

module pixel_clip_fifo #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [2:0]  in_colour,
  input  logic        in_plot,
  output logic [7:0]  out_x,
  output logic [6:0]  out_y,
  output logic [2:0]  out_colour,
  output logic        out_plot,
  input  logic        out_ready,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic [15:0] clip_count,
  output logic        overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit on each limit so SCREEN_W = 256 / SCREEN_H = 128 still
  // compare correctly against the full-width inputs.
  localparam logic [8:0]  X_LIMIT  = 9'(SCREEN_W);
  localparam logic [7:0]  Y_LIMIT  = 8'(SCREEN_H);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {
    S_EMPTY,
    S_NON_EMPTY
  } occ_state_t;

  logic [17:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  occ_state_t    state;

  logic in_range;
  logic push_req;
  logic push;
  logic pop;
  logic drop;
  logic clip;

  assign in_range = ({1'b0, in_x} < X_LIMIT) && ({1'b0, in_y} < Y_LIMIT);

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign out_plot   = (state == S_NON_EMPTY);

  // Fall-through: the head entry is read straight out of the array, so a
  // pixel written at edge k is on out_* right after that edge.
  assign {out_x, out_y, out_colour} = mem[rd_ptr];

  assign pop      = out_plot && out_ready;
  assign push_req = in_plot && in_range;
  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && fifo_full && !pop;
  assign clip     = in_plot && !in_range;

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + 1'b1;
    end else if (pop && !push) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= S_EMPTY;
      clip_count <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= S_EMPTY;
      clip_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {in_x, in_y, in_colour};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      state <= (count_next == '0) ? S_EMPTY : S_NON_EMPTY;
      if (clip && (clip_count != 16'hFFFF)) begin
        clip_count <= clip_count + 16'd1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// tb/tb_pixel_clip_fifo.sv - self-checking bench for pixel_clip_fifo

module tb_pixel_clip_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [7:0]  in_x;
  logic [6:0]  in_y;
  logic [2:0]  in_colour;
  logic        in_plot;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_colour;
  logic        out_plot;
  logic        out_ready;
  logic        fifo_full;
  logic        fifo_empty;
  logic [15:0] clip_count;
  logic        overflow;

  pixel_clip_fifo #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_x(in_x), .in_y(in_y), .in_colour(in_colour), .in_plot(in_plot),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_plot(out_plot),
    .out_ready(out_ready), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .clip_count(clip_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      if (nfail <= 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of accepted pixels plus counters.
  logic [17:0] mq[$];
  int          m_clip;
  bit          m_ovf;

  task automatic model_reset();
    mq.delete();
    m_clip = 0;
    m_ovf  = 0;
  endtask

  task automatic model_edge(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                            input bit p, input bit r, input bit cl);
    int sz;
    bit popd, inr;
    if (cl) begin
      model_reset();
    end else begin
      sz   = mq.size();
      popd = (sz > 0) && r;
      inr  = (int'(x) < 160) && (int'(y) < 120);
      if (popd) void'(mq.pop_front());
      if (p && inr) begin
        if (sz < DEPTH || popd) mq.push_back({x, y, c});
        else m_ovf = 1;
      end
      if (p && !inr && m_clip < 65535) m_clip++;
    end
  endtask

  task automatic check_model();
    logic [17:0] h;
    chk("out_plot", out_plot, mq.size() != 0);
    chk("fifo_empty", fifo_empty, mq.size() == 0);
    chk("fifo_full", fifo_full, mq.size() == DEPTH);
    chk("clip_count", clip_count, m_clip);
    chk("overflow", overflow, m_ovf);
    if (mq.size() != 0) begin
      h = mq[0];
      chk("out_x", out_x, h[17:10]);
      chk("out_y", out_y, h[9:3]);
      chk("out_colour", out_colour, h[2:0]);
    end
  endtask

  // Called just after a falling edge: drive, take the rising edge, check at the next falling edge.
  task automatic cycle(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                       input bit p, input bit r, input bit cl);
    in_x = x; in_y = y; in_colour = c; in_plot = p; out_ready = r; clear = cl;
    @(posedge clk);
    model_edge(x, y, c, p, r, cl);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    bit p;
    bit r;
    bit e_plot;
    int e_x;
    int e_y;
    int e_c;
    int e_clip;
  } vec_t;

  function automatic vec_t mkv(input int x, input int y, input int c, input bit p, input bit r,
                               input bit e_plot, input int e_x, input int e_y, input int e_c,
                               input int e_clip);
    vec_t v;
    v.x = 8'(x); v.y = 7'(y); v.c = 3'(c); v.p = p; v.r = r;
    v.e_plot = e_plot; v.e_x = e_x; v.e_y = e_y; v.e_c = e_c; v.e_clip = e_clip;
    return v;
  endfunction

  vec_t tbl[14];
  int   circ_x[$];
  int   circ_y[$];

  initial begin
    int cx, cy, d;
    int dx[8];
    int dy[8];

    tbl[0]  = mkv(10, 20, 3, 1, 0,  1, 10, 20, 3, 0);
    tbl[1]  = mkv(0, 0, 0, 0, 0,    1, 10, 20, 3, 0);
    tbl[2]  = mkv(1, 1, 1, 0, 0,    1, 10, 20, 3, 0);
    tbl[3]  = mkv(2, 2, 2, 0, 0,    1, 10, 20, 3, 0);
    tbl[4]  = mkv(3, 3, 3, 0, 0,    1, 10, 20, 3, 0);
    tbl[5]  = mkv(4, 4, 4, 0, 0,    1, 10, 20, 3, 0);
    tbl[6]  = mkv(0, 0, 0, 0, 1,    0, 0, 0, 0, 0);
    tbl[7]  = mkv(160, 5, 1, 1, 0,  0, 0, 0, 0, 1);
    tbl[8]  = mkv(5, 120, 2, 1, 0,  0, 0, 0, 0, 2);
    tbl[9]  = mkv(159, 119, 7, 1, 0, 1, 159, 119, 7, 2);
    tbl[10] = mkv(0, 0, 0, 0, 1,    0, 0, 0, 0, 2);
    tbl[11] = mkv(255, 127, 0, 1, 0, 0, 0, 0, 0, 3);
    tbl[12] = mkv(0, 0, 5, 1, 0,    1, 0, 0, 5, 3);
    tbl[13] = mkv(0, 0, 0, 0, 1,    0, 0, 0, 0, 3);

    // Reset
    rst_n = 1'b0; clear = 0; in_x = 0; in_y = 0; in_colour = 0; in_plot = 0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst out_plot", out_plot, 0);
    chk("rst fifo_empty", fifo_empty, 1);
    chk("rst fifo_full", fifo_full, 0);
    chk("rst clip_count", clip_count, 0);
    chk("rst overflow", overflow, 0);
    chk("rst out_xyc", {out_x, out_y, out_colour}, 0);
    rst_n = 1'b1;

    // Directed table
    foreach (tbl[i]) begin
      cycle(tbl[i].x, tbl[i].y, tbl[i].c, tbl[i].p, tbl[i].r, 0);
      chk("tbl out_plot", out_plot, tbl[i].e_plot);
      chk("tbl fifo_empty", fifo_empty, !tbl[i].e_plot);
      chk("tbl clip_count", clip_count, tbl[i].e_clip);
      chk("tbl overflow", overflow, 0);
      if (tbl[i].e_plot) begin
        chk("tbl out_x", out_x, tbl[i].e_x);
        chk("tbl out_y", out_y, tbl[i].e_y);
        chk("tbl out_colour", out_colour, tbl[i].e_c);
      end
    end

    // Overrun: nine pushes into an eight-deep FIFO, then drain
    for (int i = 1; i <= 9; i++) begin
      cycle(8'(i * 10), 7'(i), 3'(i), 1, 0, 0);
      chk("ovr fifo_full", fifo_full, i >= 8);
      chk("ovr overflow", overflow, i == 9);
    end
    for (int i = 1; i <= 8; i++) begin
      chk("drain order", out_x, i * 10);
      cycle(0, 0, 0, 0, 1, 0);
    end
    chk("drain empty", fifo_empty, 1);
    chk("drain overflow sticky", overflow, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("clear overflow", overflow, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) cycle(8'(100 + i), 7'(i), 3'(i), 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      cycle(8'(120 + k), 7'(50 + k), 3'(k), 1, 1, 0);
      chk("pp fifo_full", fifo_full, 1);
      chk("pp overflow", overflow, 0);
      chk("pp head", out_x, 100 + k);
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 1, 0);
    chk("pp drained", fifo_empty, 1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(8'($urandom_range(0, 255)), 7'($urandom_range(0, 127)), 3'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);
    end

    // Clip counter saturation
    for (int i = 0; i < 70000; i++) begin
      if ($urandom_range(0, 1) != 0)
        cycle(8'($urandom_range(160, 255)), 7'($urandom_range(0, 127)), 3'($urandom), 1,
              $urandom_range(0, 1) != 0, 0);
      else
        cycle(8'($urandom_range(0, 255)), 7'($urandom_range(120, 127)), 3'($urandom), 1,
              $urandom_range(0, 1) != 0, 0);
    end
    chk("sat clip_count", clip_count, 65535);
    cycle(0, 0, 0, 0, 0, 1);
    chk("sat clear clip", clip_count, 0);
    chk("sat clear ovf", overflow, 0);
    chk("sat clear empty", fifo_empty, 1);

    // Circle stream (centre 157,117, radius 3) with a reset part way through
    cx = 0; cy = 3; d = 3 - 2 * 3;
    while (cy >= cx) begin
      dx = '{cx, -cx, cx, -cx, cy, -cy, cy, -cy};
      dy = '{cy, cy, -cy, -cy, cx, cx, -cx, -cx};
      for (int k = 0; k < 8; k++) begin
        circ_x.push_back(157 + dx[k]);
        circ_y.push_back(117 + dy[k]);
      end
      cx++;
      if (d > 0) begin
        cy--;
        d = d + 4 * (cx - cy) + 10;
      end else begin
        d = d + 4 * cx + 6;
      end
    end
    for (int i = 0; i < circ_x.size(); i++) begin
      cycle(8'(circ_x[i]), 7'(circ_y[i]), 3'(i), 1, 1, 0);
      if (circ_x[i] <= 159 && circ_y[i] <= 119) begin
        chk("circ latency", out_plot, 1);
        chk("circ x", out_x, circ_x[i]);
        chk("circ y", out_y, circ_y[i]);
      end
      if (i == 12) begin
        in_plot = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst out_plot", out_plot, 0);
        chk("midrst empty", fifo_empty, 1);
        chk("midrst clip", clip_count, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0, 0, 1, 0);
        chk("post rst idle", out_plot, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
